// File: rtl/adder_rv_arbiter.sv
// adder_rv_arbiter: round-robin front end that shares one in-order ready/valid
// adder among N requesters. The requester ID of each issued operation is kept
// in a tag FIFO so that every adder result is steered back to its owner.
module adder_rv_arbiter #(
  parameter int W = 32,
  parameter int N = 4,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic [N-1:0]         rsp_valid,
  input  logic [N-1:0]         rsp_ready,
  output logic [N*W-1:0]       rsp_sum,
  output logic                 add_in_valid,
  input  logic                 add_in_ready,
  output logic [W-1:0]         add_in_a,
  output logic [W-1:0]         add_in_b,
  input  logic                 add_out_valid,
  output logic                 add_out_ready,
  input  logic [W-1:0]         add_out_sum,
  output logic [$clog2(D):0]   outstanding,
  output logic                 err_orphan
);

  localparam int IW = $clog2(N);
  localparam int PW = $clog2(D);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] head;
  logic [IW-1:0] tag_mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          tag_full;
  logic          tag_empty;
  logic          issue;
  logic          pop;

  // Round-robin search: scan from the highest offset down so the last hit is
  // the first valid requester at or after rr_ptr.
  always_comb begin
    int idx;
    idx    = 0;
    winner = rr_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req_valid[idx]) winner = IW'(idx);
    end
  end

  assign tag_full  = (count == (PW + 1)'(D));
  assign tag_empty = (count == '0);

  // Issue side never looks at add_in_ready, and a full tag FIFO blocks issue
  // even when a pop happens in the same cycle, so no rsp->req combinational path.
  assign add_in_valid = !rst && (|req_valid) && !tag_full;
  assign add_in_a     = req_a[int'(winner)*W +: W];
  assign add_in_b     = req_b[int'(winner)*W +: W];
  assign issue        = add_in_valid && add_in_ready;

  // One-hot accept to the granted requester on an actual issue.
  always_comb begin
    req_ready = '0;
    if (issue) req_ready[winner] = 1'b1;
  end

  assign head          = tag_mem[rd_ptr];
  assign add_out_ready = !rst && !tag_empty && rsp_ready[head];
  assign pop           = add_out_valid && add_out_ready;
  assign rsp_sum       = {N{add_out_sum}};
  assign outstanding   = count;

  // Return path: only the owner of the head tag sees the result as valid.
  always_comb begin
    rsp_valid = '0;
    if (!rst && add_out_valid && !tag_empty) rsp_valid[head] = 1'b1;
  end

  // Arbitration pointer, tag FIFO pointers/occupancy and the sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (issue) begin
        rr_ptr <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (add_out_valid && tag_empty) err_orphan <= 1'b1;
    end
  end

  // Tag storage needs no reset; entries are only read while occupancy covers them.
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= winner;
  end

endmodule

// File: tb/tb_adder_rv_arbiter.sv
// Bench for adder_rv_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level scoreboard and a behavioural adder.
module tb_adder_rv_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]     req_a, req_b, rsp_sum;
  logic               add_in_valid, add_in_ready, add_out_valid, add_out_ready;
  logic [W-1:0]       add_in_a, add_in_b, add_out_sum;
  logic [$clog2(D):0] outstanding;
  logic               err_orphan;

  adder_rv_arbiter #(.W(W), .N(N), .D(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .add_in_valid(add_in_valid), .add_in_ready(add_in_ready),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_out_valid(add_out_valid), .add_out_ready(add_out_ready),
    .add_out_sum(add_out_sum),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [W-1:0] sum;
  } ent_t;

  ent_t         sb[$];      // expected results in issue order
  logic [W-1:0] aq[$];      // behavioural adder pipeline contents
  int           m_rr;
  bit           m_err;
  int           n_chk = 0;
  int           n_err = 0;

  bit           pend[N];
  logic [W-1:0] pa[N], pb[N], fa[N], fb[N];
  int           left[N];
  int           p_new;
  bit           use_fixed, rdy_rand, force_ov;
  logic [N-1:0] rdy_fixed;
  int           cap;
  int           glog[$];
  logic [W-1:0] obs_sum[N];
  int           n_rsp, n_iss;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic drive_io();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && left[i] > 0 && $urandom_range(99) < p_new) begin
        pend[i] = 1'b1;
        left[i]--;
        if (use_fixed) begin
          pa[i] = fa[i];
          pb[i] = fb[i];
        end else begin
          pa[i] = ($urandom_range(7) == 0) ? '1 : W'($urandom);
          pb[i] = W'($urandom);
        end
      end
      req_valid[i]     = pend[i];
      req_a[i*W +: W]  = pa[i];
      req_b[i*W +: W]  = pb[i];
      rsp_ready[i]     = rdy_fixed[i] | (rdy_rand && $urandom_range(99) < 60);
    end
    add_in_ready  = (aq.size() < cap);
    add_out_valid = force_ov || (aq.size() > 0);
    add_out_sum   = (aq.size() > 0) ? aq[0] : 32'hDEAD_BEEF;
  endtask

  task automatic step();
    int           win, head;
    bit           exp_iv, exp_ordy, fire_in, fire_out;
    logic [N-1:0] exp_rr, exp_rv;
    logic [W-1:0] ain;
    @(negedge clk);
    win    = rr_pick(m_rr, req_valid);
    exp_iv = !rst && (|req_valid) && (sb.size() < D);
    chk("add_in_valid", add_in_valid, exp_iv);
    exp_rr = '0;
    if (exp_iv && add_in_ready) exp_rr[win] = 1'b1;
    chk("req_ready", req_ready, exp_rr);
    if (exp_iv) begin
      chk("add_in_a", add_in_a, pa[win]);
      chk("add_in_b", add_in_b, pb[win]);
    end
    head   = (sb.size() > 0) ? sb[0].id : 0;
    exp_rv = '0;
    if (!rst && add_out_valid && sb.size() > 0) exp_rv[head] = 1'b1;
    chk("rsp_valid", rsp_valid, exp_rv);
    exp_ordy = !rst && (sb.size() > 0) && rsp_ready[head];
    chk("add_out_ready", add_out_ready, exp_ordy);
    if (exp_rv != '0) chk("rsp_sum", rsp_sum[head*W +: W], sb[0].sum);
    chk("outstanding", outstanding, 64'(sb.size()));
    chk("err_orphan", err_orphan, m_err);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) glog.push_back(i);
      if (rsp_valid[i] && rsp_ready[i]) begin
        obs_sum[i] = rsp_sum[i*W +: W];
        n_rsp++;
      end
    end
    ain      = add_in_a + add_in_b;
    fire_in  = exp_iv && add_in_ready;
    fire_out = add_out_valid && exp_ordy;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      aq.delete();
      m_rr  = 0;
      m_err = 1'b0;
    end else begin
      if (add_out_valid && sb.size() == 0) m_err = 1'b1;
      if (fire_out) begin
        void'(sb.pop_front());
        if (aq.size() > 0) void'(aq.pop_front());
      end
      if (fire_in) begin
        sb.push_back('{win, pa[win] + pb[win]});
        aq.push_back(ain);
        m_rr      = (win + 1) % N;
        pend[win] = 1'b0;
        n_iss++;
      end
    end
    #1;
    drive_io();
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; left[i] = 0; pa[i] = '0; pb[i] = '0;
      fa[i] = '0; fb[i] = '0; obs_sum[i] = '0;
    end
    p_new = 100; use_fixed = 1'b1; rdy_rand = 1'b0; force_ov = 1'b0;
    rdy_fixed = '1; cap = 2;
  endtask

  task automatic do_reset();
    clear_cfg();
    drive_io();
    rst = 1'b1;
    step();
    rst = 1'b0;
    glog.delete();
  endtask

  function automatic bit idle();
    for (int i = 0; i < N; i++) if (pend[i] || left[i] > 0) return 1'b0;
    return (sb.size() == 0);
  endfunction

  initial begin
    clear_cfg();
    drive_io();
    step();
    step();
    rst = 1'b0;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err_orphan", err_orphan, 0);
    chk("rst_rsp_valid", rsp_valid, 0);

    // single requester
    do_reset();
    fa[2] = 5; fb[2] = 7; left[2] = 1;
    drive_io();
    step();
    chk("t1_outstanding1", outstanding, 1);
    chk("t1_req_ready_low", req_ready, 0);
    chk("t1_rsp_valid", rsp_valid, 4'b0100);
    chk("t1_rsp_sum", rsp_sum[2*W +: W], 12);
    step();
    chk("t1_outstanding0", outstanding, 0);
    chk("t1_grants", glog.size(), 1);
    chk("t1_grant_id", glog[0], 2);

    // round-robin fairness
    do_reset();
    for (int i = 0; i < N; i++) begin fa[i] = W'(i); fb[i] = 100; left[i] = 2; end
    drive_io();
    repeat (12) step();
    for (int k = 0; k < 8; k++) chk("t2_order", glog[k], k % N);
    for (int i = 0; i < N; i++) chk("t2_sum", obs_sum[i], 100 + i);
    for (int i = 0; i < N; i++) left[i] = 1;
    drive_io();
    repeat (8) step();
    chk("t2_rr_wrap", glog[8], 0);

    // backpressure fill, then tag-full gating, then drain
    do_reset();
    use_fixed = 1'b0; rdy_fixed = '0; left[0] = 100; left[1] = 100;
    drive_io();
    repeat (6) step();
    chk("t3_out_adder_full", outstanding, 2);
    chk("t3_stall_valid", add_in_valid, 1);
    chk("t3_stall_ready", req_ready, 0);
    cap = 8;
    drive_io();
    repeat (6) step();
    chk("t3_out_tag_full", outstanding, D);
    chk("t3_tag_full_gate", add_in_valid, 0);
    chk("t3_grant0", glog[0], 0);
    chk("t3_grant1", glog[1], 1);
    left[0] = 0; left[1] = 0; rdy_fixed = '1;
    drive_io();
    repeat (16) step();
    chk("t3_drained", outstanding, 0);

    // head-of-line blocking
    do_reset();
    fa[1] = 11; fb[1] = 1; fa[3] = 33; fb[3] = 3; rdy_fixed = 4'b1101;
    left[1] = 1;
    drive_io();
    step();
    left[3] = 1;
    drive_io();
    step();
    repeat (3) step();
    chk("t4_hol_valid", rsp_valid, 4'b0010);
    chk("t4_hol_out", outstanding, 2);
    rdy_fixed = '1;
    drive_io();
    repeat (4) step();
    chk("t4_sum1", obs_sum[1], 12);
    chk("t4_sum3", obs_sum[3], 36);
    chk("t4_out", outstanding, 0);

    // wrap-around sum, then 20 random back-to-back ops
    do_reset();
    fa[0] = '1; fb[0] = 2; left[0] = 1;
    drive_io();
    repeat (3) step();
    chk("t5_wrap_sum", obs_sum[0], 1);
    use_fixed = 1'b0; rdy_rand = 1'b1; rdy_fixed = '0;
    n_rsp = 0; n_iss = 0;
    for (int i = 0; i < N; i++) left[i] = 5;
    drive_io();
    for (int c = 0; c < 500 && !idle(); c++) step();
    chk("t5_timeout", idle(), 1);
    chk("t5_rsp_count", n_rsp, 20);
    chk("t5_iss_count", n_iss, 20);

    // longer random traffic with varying adder capacity
    n_rsp = 0; n_iss = 0; p_new = 50;
    for (int i = 0; i < N; i++) left[i] = 50;
    drive_io();
    for (int c = 0; c < 5000 && !idle(); c++) begin
      if (c % 40 == 0) cap = ($urandom_range(1) == 0) ? 2 : 8;
      step();
    end
    chk("rand_timeout", idle(), 1);
    chk("rand_rsp_count", n_rsp, n_iss);

    // reset mid-flight, then orphan result
    do_reset();
    use_fixed = 1'b0; rdy_fixed = '0; left[0] = 2; left[2] = 2;
    drive_io();
    for (int c = 0; c < 50 && sb.size() < 2; c++) step();
    chk("t6_fill", outstanding, 2);
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; left[i] = 0; end
    drive_io();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    force_ov = 1'b1;
    drive_io();
    #1;
    chk("t6_orphan_ready", add_out_ready, 0);
    step();
    chk("t6_orphan_set", err_orphan, 1);
    force_ov = 1'b0;
    drive_io();
    repeat (3) step();
    chk("t6_orphan_sticky", err_orphan, 1);
    do_reset();
    chk("t6_orphan_clear", err_orphan, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
